bcd_digit_editor: RTL and testbench

- Multi-digit, parametrised digit-entry register for the calculator keypad/operand path.
- Supersedes the single-digit increment-on-edge block:
  - N digits of configurable radix.
  - Increment and decrement.
  - A cursor selecting the edited digit.
  - Optional ripple carry/borrow mode.
  - Parallel load and clear.
  - Wrap/overflow indication.
- All button inputs are synchronised and edge-detected inside the clk domain; no derived clocks.
- Output feeds the operand latch and the seven-segment display mux.

---
 rtl/calc_pkg.sv | 35 +++
 rtl/sync_edge_det.sv | 27 ++
 rtl/bcd_digit_editor.sv | 106 ++++++++++
 tb/tb_bcd_digit_editor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared digit width, radix default and per-digit arithmetic helpers
package calc_pkg;

  localparam int DIGIT_W       = 4;
  localparam int DEFAULT_RADIX = 10;

  // Values above radix-1 never reach the digit register; they collapse to the top digit.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                     input int radix);
    logic [DIGIT_W-1:0] top;
    top = DIGIT_W'(radix - 1);
    if (value > top) return top;
    return value;
  endfunction

  // Returns {carry, digit}; anything at or above radix-1 rolls over to 0.
  function automatic logic [DIGIT_W:0] next_digit(input logic [DIGIT_W-1:0] value,
                                                  input int radix);
    logic [DIGIT_W-1:0] top;
    top = DIGIT_W'(radix - 1);
    if (value >= top) return {1'b1, {DIGIT_W{1'b0}}};
    return {1'b0, value + DIGIT_W'(1)};
  endfunction

  // Returns {borrow, digit}; 0 borrows and becomes radix-1.
  function automatic logic [DIGIT_W:0] prev_digit(input logic [DIGIT_W-1:0] value,
                                                  input int radix);
    logic [DIGIT_W-1:0] top;
    top = DIGIT_W'(radix - 1);
    if (value == '0) return {1'b1, top};
    if (value > top) return {1'b0, top};
    return {1'b0, value - DIGIT_W'(1)};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - button synchroniser followed by a rising-edge pulse generator
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // History resets low, so a button held through reset still yields one pulse.
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/bcd_digit_editor.sv
// rtl/bcd_digit_editor.sv - multi-digit keypad entry register with cursor, carry mode, load and clear
module bcd_digit_editor
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int RADIX       = DEFAULT_RADIX,
  parameter int SYNC_STAGES = 2,
  parameter int CUR_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inc_btn,
  input  logic                          dec_btn,
  input  logic                          left_btn,
  input  logic                          right_btn,
  input  logic                          carry_en,
  input  logic                          clr,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic [CUR_W-1:0]              cursor,
  output logic                          wrap
);

  logic inc_p, dec_p, left_p, right_p;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_inc (
    .clk(clk), .rst(rst), .din(inc_btn), .pulse(inc_p)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
    .clk(clk), .rst(rst), .din(dec_btn), .pulse(dec_p)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_left (
    .clk(clk), .rst(rst), .din(left_btn), .pulse(left_p)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_right (
    .clk(clk), .rst(rst), .din(right_btn), .pulse(right_p)
  );

  logic do_inc, do_dec, do_edit, move_left, move_right;

  assign do_inc     = inc_p & ~dec_p;
  assign do_dec     = dec_p & ~inc_p;
  assign do_edit    = do_inc | do_dec;
  assign move_left  = left_p & ~right_p;
  assign move_right = right_p & ~left_p;

  logic [NUM_DIGITS:0]                 chain;
  logic [NUM_DIGITS-1:0]               touch;
  logic [NUM_DIGITS-1:0]               cout;
  logic [DIGIT_W*NUM_DIGITS-1:0]       edit_val;
  logic [DIGIT_W*NUM_DIGITS-1:0]       load_clamped;
  logic                                wrap_next;

  assign chain[0] = 1'b0;

  // The chain only ever starts at the cursor, so digits below it stay untouched.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] cur;
    logic [DIGIT_W:0]   up;
    logic [DIGIT_W:0]   dn;
    logic               sel;

    assign cur      = digits[DIGIT_W*i +: DIGIT_W];
    assign up       = next_digit(cur, RADIX);
    assign dn       = prev_digit(cur, RADIX);
    assign sel      = (cursor == CUR_W'(i));
    assign touch[i] = sel | (carry_en & chain[i]);
    assign cout[i]  = touch[i] & (do_dec ? dn[DIGIT_W] : up[DIGIT_W]);
    assign chain[i+1] = cout[i];

    assign edit_val[DIGIT_W*i +: DIGIT_W] =
      touch[i] ? (do_dec ? dn[DIGIT_W-1:0] : up[DIGIT_W-1:0]) : cur;
    assign load_clamped[DIGIT_W*i +: DIGIT_W] =
      clamp_digit(load_val[DIGIT_W*i +: DIGIT_W], RADIX);
  end

  // Single-digit mode wraps on the selected digit; ripple mode only on carry out of the MSD.
  assign wrap_next = carry_en ? chain[NUM_DIGITS] : (|cout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '0;
      cursor <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        digits <= '0;
      end else if (load) begin
        digits <= load_clamped;
      end else begin
        if (do_edit) begin
          digits <= edit_val;
          wrap   <= wrap_next;
        end
        if (move_left) begin
          cursor <= (cursor == CUR_W'(NUM_DIGITS - 1)) ? '0 : cursor + CUR_W'(1);
        end else if (move_right) begin
          cursor <= (cursor == '0) ? CUR_W'(NUM_DIGITS - 1) : cursor - CUR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_editor.sv
// tb/tb_bcd_digit_editor.sv - scoreboard bench for bcd_digit_editor against a value-level model
module tb_bcd_digit_editor;

  localparam int N  = 4;
  localparam int R  = 10;
  localparam int S  = 2;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            inc_btn = 1'b0, dec_btn = 1'b0, left_btn = 1'b0, right_btn = 1'b0;
  logic            carry_en = 1'b0, clr = 1'b0, load = 1'b0;
  logic [4*N-1:0]  load_val = '0;
  logic [4*N-1:0]  digits;
  logic [CW-1:0]   cursor;
  logic            wrap;

  bcd_digit_editor #(.NUM_DIGITS(N), .RADIX(R), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .left_btn(left_btn), .right_btn(right_btn), .carry_en(carry_en),
    .clr(clr), .load(load), .load_val(load_val),
    .digits(digits), .cursor(cursor), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*N-1:0] dig;
    int             cur;
    int             wraps;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   wrap_cnt = 0;
  logic obs = 1'b0;

  int md[N];
  int mcur = 0;

  function automatic logic [4*N-1:0] pack_model();
    logic [4*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(md[i]);
    return v;
  endfunction

  function automatic int pow_r(input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * R;
    return p;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rst) begin
      wrap_cnt = 0;
    end else begin
      if (wrap) wrap_cnt++;
      if (obs) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("digits", int'(digits), int'(e.dig));
          check("cursor", int'(cursor), e.cur);
          check("wrap_pulses", wrap_cnt, e.wraps);
        end
        wrap_cnt = 0;
      end
    end
  end

  task automatic push_expect(input int wraps);
    exp_t e;
    e.dig   = pack_model();
    e.cur   = mcur;
    e.wraps = wraps;
    exp_q.push_back(e);
  endtask

  task automatic observe();
    @(negedge clk) obs = 1'b1;
    @(negedge clk) obs = 1'b0;
  endtask

  // Value-level model: the number is treated as an integer in base R.
  task automatic model_buttons(input bit i, input bit d, input bit l, input bit r,
                               output int wraps);
    int val, full, nv;
    wraps = 0;
    if (i != d) begin
      if (carry_en) begin
        val = 0;
        for (int k = 0; k < N; k++) val += md[k] * pow_r(k);
        full = pow_r(N);
        nv = i ? val + pow_r(mcur) : val - pow_r(mcur);
        if (nv >= full) begin nv -= full; wraps = 1; end
        if (nv < 0)     begin nv += full; wraps = 1; end
        for (int k = 0; k < N; k++) md[k] = (nv / pow_r(k)) % R;
      end else if (i) begin
        wraps = (md[mcur] == R - 1) ? 1 : 0;
        md[mcur] = (md[mcur] + 1) % R;
      end else begin
        wraps = (md[mcur] == 0) ? 1 : 0;
        md[mcur] = (md[mcur] + R - 1) % R;
      end
    end
    if (l && !r) mcur = (mcur + 1) % N;
    if (r && !l) mcur = (mcur + N - 1) % N;
  endtask

  task automatic press(input bit i, input bit d, input bit l, input bit r);
    int wraps;
    @(negedge clk);
    inc_btn = i; dec_btn = d; left_btn = l; right_btn = r;
    repeat ($urandom_range(3, 1)) @(negedge clk);
    inc_btn = 0; dec_btn = 0; left_btn = 0; right_btn = 0;
    repeat (S + 3) @(negedge clk);
    model_buttons(i, d, l, r, wraps);
    push_expect(wraps);
    observe();
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input bit with_clr, input bit with_load);
    @(negedge clk);
    load_val = v; load = with_load; clr = with_clr;
    @(negedge clk);
    load = 0; clr = 0;
    repeat (2) @(negedge clk);
    if (with_clr) begin
      for (int k = 0; k < N; k++) md[k] = 0;
    end else if (with_load) begin
      for (int k = 0; k < N; k++) md[k] = (int'(v[4*k +: 4]) > R - 1) ? R - 1 : int'(v[4*k +: 4]);
    end
    push_expect(0);
    observe();
  endtask

  initial begin
    int lat;
    for (int k = 0; k < N; k++) md[k] = 0;

    // Button held through reset release must give exactly one increment.
    inc_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_digits", int'(digits), 0);
    check("reset_cursor", int'(cursor), 0);
    check("reset_wrap", int'(wrap), 0);
    rst = 1'b0;
    lat = 0;
    while (digits == '0 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("reset_release_latency", lat, S + 1);
    md[0] = 1;
    repeat (8) @(negedge clk);
    push_expect(0);
    observe();
    inc_btn = 1'b0;
    repeat (S + 2) @(negedge clk);

    carry_en = 1'b0;
    do_load(16'h0009, 0, 1);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);

    carry_en = 1'b1;
    do_load(16'h0999, 0, 1);
    press(1, 0, 0, 0);
    do_load(16'h9999, 0, 1);
    press(1, 0, 0, 0);
    do_load(16'h0000, 0, 1);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);

    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(0, 0, 0, 1);
    press(0, 0, 1, 0);
    do_load(16'h1234, 0, 1);
    press(1, 1, 0, 0);
    press(0, 0, 1, 1);
    press(1, 0, 1, 0);
    do_load(16'hFA3C, 0, 1);
    do_load(16'h5678, 1, 1);

    for (int n = 0; n < 160; n++) begin
      int op;
      if ($urandom_range(9, 0) == 0) carry_en = $urandom_range(1, 0);
      op = $urandom_range(11, 0);
      case (op)
        0:       do_load(16'($urandom), 0, 1);
        1:       do_load(16'($urandom), 1, $urandom_range(1, 0));
        2, 3:    press(1, 0, 0, 0);
        4, 5:    press(0, 1, 0, 0);
        6:       press(0, 0, 1, 0);
        7:       press(0, 0, 0, 1);
        default: press(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      endcase
    end

    // Asynchronous reset in mid-cycle with a pulse in flight.
    do_load(16'h4321, 0, 1);
    press(0, 0, 1, 0);
    @(negedge clk) inc_btn = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_reset_digits", int'(digits), 0);
    check("async_reset_cursor", int'(cursor), 0);
    inc_btn = 1'b0;
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < N; k++) md[k] = 0;
    mcur = 0;
    repeat (S + 3) @(negedge clk);
    push_expect(0);
    observe();
    carry_en = 1'b1;
    press(0, 1, 0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
